restoring_divider4: RTL and testbench



---
 rtl/divider_pkg.sv | 13 +
 rtl/fullsubtractor4.sv | 22 ++
 rtl/restoring_divider4.sv | 106 ++++++++++
 tb/tb_restoring_divider4.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the 4-bit restoring divider.
package divider_pkg;

    localparam int unsigned DIV_W = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fullsubtractor4.sv
// 4-bit ripple-borrow subtractor: diff = a - b - bin, bout set on underflow.
module fullsubtractor4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic borrow;

    always_comb begin
        diff   = '0;
        borrow = bin;
        for (int unsigned i = 0; i < 4; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        bout = borrow;
    end

endmodule

// File: rtl/restoring_divider4.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per cycle,
// with start/busy/done handshake and a single-cycle divide-by-zero path.
module restoring_divider4
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t state, state_next;

    logic [DIV_W-1:0] q_w, d_w, r_w;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] trial, diff, r_next, q_next;
    logic             bout;
    logic             accept;
    logic             last_iter;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_iter = (cnt == '1);

    // Partial remainder never exceeds the dividend prefix, so 4 bits suffice.
    assign trial = {r_w[DIV_W-2:0], q_w[DIV_W-1]};

    fullsubtractor4 u_sub (
        .a    (trial),
        .b    (d_w),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    assign r_next = bout ? trial : diff;
    assign q_next = {q_w[DIV_W-2:0], ~bout};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = (divisor == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_next = (divisor == '0) ? ST_DONE : ST_RUN;
                else       state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_w         <= '0;
            d_w         <= '0;
            r_w         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_w <= dividend;
            d_w <= divisor;
            r_w <= '0;
            cnt <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            q_w <= q_next;
            r_w <= r_next;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider4.sv
// Directed self-checking bench for restoring_divider4.
module tb_restoring_divider4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    restoring_divider4 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advances until done, counting cycles (cyc starts at 1 after the start edge).
    task automatic wait_done(inout int cyc, output int busy_cnt);
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        n_cmp++; if ({quotient, remainder} !== 8'h00) begin n_err++; $display("FAIL reset_qr: got %h expected 00", {quotient, remainder}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cyc, bc;
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL basic_q: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL basic_r: got %0d expected 1", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL basic_q_hold: got %0d expected 4", quotient); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        dividend = 4'd7; divisor = 4'd9; start = 1'b1;
        step();
        cyc = 1;
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 5", cyc); end
        n_cmp++; if (quotient !== 4'd0) begin n_err++; $display("FAIL b2b_first_q: got %0d expected 0", quotient); end
        n_cmp++; if (remainder !== 4'd7) begin n_err++; $display("FAIL b2b_first_r: got %0d expected 7", remainder); end
        dividend = 4'd15; divisor = 4'd1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle: got busy %b expected 1", busy); end
        cyc = 1;
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 5", cyc); end
        n_cmp++; if (quotient !== 4'd15) begin n_err++; $display("FAIL b2b_second_q: got %0d expected 15", quotient); end
        n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL b2b_second_r: got %0d expected 0", remainder); end
        step();
    endtask

    task automatic test_sweep();
        int cyc, bc;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                dividend = 4'(a); divisor = 4'(b); start = 1'b1;
                step();
                start = 1'b0;
                cyc = 1;
                wait_done(cyc, bc);
                n_cmp++;
                if (done !== 1'b1 || quotient !== 4'(a / b) || remainder !== 4'(a % b)) begin
                    n_err++;
                    $display("FAIL sweep %0d/%0d: got done=%b q=%0d r=%0d expected done=1 q=%0d r=%0d",
                             a, b, done, quotient, remainder, a / b, a % b);
                end
            end
        end
        step();
    endtask

    task automatic test_div_zero();
        dividend = 4'd10; divisor = 4'd0; start = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dz_busy_before: got %b expected 0", busy); end
        step();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL dz_done: got %b expected 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dz_busy: got %b expected 0", busy); end
        n_cmp++; if (quotient !== 4'hF) begin n_err++; $display("FAIL dz_q: got %h expected f", quotient); end
        n_cmp++; if (remainder !== 4'd10) begin n_err++; $display("FAIL dz_r: got %0d expected 10", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        step();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL dz_after: got done=%b busy=%b expected 0 0", done, busy); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag_hold: got %b expected 1", div_by_zero); end
    endtask

    task automatic test_start_ignored();
        int cyc, bc;
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL ign_dbz_cleared: got %b expected 0", div_by_zero); end
        step(); cyc++;
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
        step(); cyc++;
        start = 1'b0;
        n_cmp++; if (quotient !== 4'hF || remainder !== 4'd10) begin n_err++; $display("FAIL ign_hold_during_run: got q=%h r=%0d expected q=f r=10", quotient, remainder); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b expected 1", busy); end
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL ign_latency: got %0d expected 5", cyc); end
        n_cmp++; if (quotient !== 4'd2) begin n_err++; $display("FAIL ign_q: got %0d expected 2", quotient); end
        n_cmp++; if (remainder !== 4'd2) begin n_err++; $display("FAIL ign_r: got %0d expected 2", remainder); end
        step();
    endtask

    task automatic test_reset_abort();
        int cyc, bc, seen;
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({quotient, remainder} !== 8'h00) begin n_err++; $display("FAIL abort_qr: got %h expected 00", {quotient, remainder}); end
        n_cmp++; if ({busy, done, div_by_zero} !== 3'b000) begin n_err++; $display("FAIL abort_flags: got %b expected 000", {busy, done, div_by_zero}); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL abort_fresh_latency: got %0d expected 5", cyc); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL abort_fresh_q: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd2) begin n_err++; $display("FAIL abort_fresh_r: got %0d expected 2", remainder); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_sweep();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
